window3x3_gen: RTL and testbench

- Sits directly downstream of the frame RAM in the salt-and-pepper filter path.
- On `start`, it scans one stored frame in raster order through the RAM read port.
- It rebuilds 3x3 neighbourhoods with two line buffers and streams one window per interior pixel to the median stage.
- Border pixels produce no window; the downstream stage copies them unfiltered.

---
 rtl/window3x3_gen.sv | 132 +++++++++++++
 tb/tb_window3x3_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/window3x3_gen.sv
// 3x3 neighbourhood generator: raster-scans a stored frame through a 2-cycle-latency RAM
// and emits one window per interior pixel using two line buffers.
module window3x3_gen #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  win_valid,
  output logic [71:0]           win,
  output logic [ADDR_W/2-1:0]   win_row,
  output logic [ADDR_W/2-1:0]   win_col
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = ADDR_W / 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        drain_reg;
  logic [1:0]        vpipe_reg;
  logic [CW-1:0]     col_reg;
  logic [RW-1:0]     row_reg;
  logic [23:0]       wcol1_reg, wcol2_reg;
  logic [7:0]        lb0 [IMG_W];
  logic [7:0]        lb1 [IMG_W];
  logic              pix_valid;
  logic [23:0]       cur_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (start) state_next = READ;
      READ:  if (addr_reg == LAST_ADDR) state_next = DRAIN;
      DRAIN: if (drain_reg == 2'd2) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = addr_reg;
    unique case (state_reg)
      READ:    begin busy = 1'b1; rd_en = 1'b1; end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Address is held at 0 outside READ so every scan starts from the frame origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      drain_reg <= '0;
    end else begin
      if (state_reg == READ && addr_reg != LAST_ADDR) addr_reg <= addr_reg + ADDR_W'(1);
      else                                            addr_reg <= '0;
      if (state_reg == DRAIN) drain_reg <= drain_reg + 2'd1;
      else                    drain_reg <= '0;
    end
  end

  assign pix_valid = vpipe_reg[1];
  // Column triple {row r-2, row r-1, row r} at the arriving pixel's column.
  assign cur_col   = {lb0[col_reg], lb1[col_reg], rd_data};

  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb0[col_reg] <= lb1[col_reg];
      lb1[col_reg] <= rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_reg <= '0;
      col_reg   <= '0;
      row_reg   <= '0;
      wcol1_reg <= '0;
      wcol2_reg <= '0;
      win_valid <= 1'b0;
      win       <= '0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      vpipe_reg <= {vpipe_reg[0], rd_en};
      win_valid <= 1'b0;
      if (state_reg == IDLE && start) begin
        col_reg <= '0;
        row_reg <= '0;
      end else if (pix_valid) begin
        wcol2_reg <= wcol1_reg;
        wcol1_reg <= cur_col;
        if (row_reg >= RW'(2) && col_reg >= CW'(2)) begin
          win_valid <= 1'b1;
          win <= {cur_col[7:0],   wcol1_reg[7:0],   wcol2_reg[7:0],
                  cur_col[15:8],  wcol1_reg[15:8],  wcol2_reg[15:8],
                  cur_col[23:16], wcol1_reg[23:16], wcol2_reg[23:16]};
          win_row <= PW'(row_reg - RW'(1));
          win_col <= PW'(col_reg - CW'(1));
        end
        if (col_reg == LAST_COL) begin
          col_reg <= '0;
          row_reg <= (row_reg == LAST_ROW) ? '0 : row_reg + RW'(1);
        end else begin
          col_reg <= col_reg + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_window3x3_gen.sv
// Bench for window3x3_gen: three parameterisations driven one at a time against a
// 2-cycle-latency RAM model, with windows checked against a reference scoreboard.
module tb_window3x3_gen;
  typedef struct packed {
    logic [1:0]  inst;
    logic [71:0] w;
    logic [7:0]  r;
    logic [7:0]  c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_v [3];
  logic        start_v [3];
  logic        busy_v [3], done_v [3], rd_en_v [3], win_valid_v [3];
  logic [71:0] win_v [3];
  logic [7:0]  p1 [3], p2 [3];
  logic [3:0]  addr0, addr2;
  logic [15:0] addr1;
  logic [1:0]  row0, col0, row2, col2;
  logic [7:0]  row1, col1;
  logic [15:0] addr_v [3];
  logic [7:0]  row_v [3], col_v [3];
  logic [7:0]  mem [3][65536];

  assign addr_v[0] = {12'd0, addr0};
  assign addr_v[1] = addr1;
  assign addr_v[2] = {12'd0, addr2};
  assign row_v[0]  = {6'd0, row0};
  assign col_v[0]  = {6'd0, col0};
  assign row_v[1]  = row1;
  assign col_v[1]  = col1;
  assign row_v[2]  = {6'd0, row2};
  assign col_v[2]  = {6'd0, col2};

  window3x3_gen #(.IMG_W(4), .IMG_H(4), .ADDR_W(4)) u0 (
    .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .rd_en(rd_en_v[0]), .rd_addr(addr0), .rd_data(p2[0]), .win_valid(win_valid_v[0]),
    .win(win_v[0]), .win_row(row0), .win_col(col0));
  window3x3_gen #(.IMG_W(256), .IMG_H(256), .ADDR_W(16)) u1 (
    .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .rd_en(rd_en_v[1]), .rd_addr(addr1), .rd_data(p2[1]), .win_valid(win_valid_v[1]),
    .win(win_v[1]), .win_row(row1), .win_col(col1));
  window3x3_gen #(.IMG_W(5), .IMG_H(3), .ADDR_W(4)) u2 (
    .clk(clk), .rst_n(rst_n_v[2]), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .rd_en(rd_en_v[2]), .rd_addr(addr2), .rd_data(p2[2]), .win_valid(win_valid_v[2]),
    .win(win_v[2]), .win_row(row2), .win_col(col2));

  // RAM model: junk on the data bus whenever no read was issued two cycles earlier.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      p1[i] <= rd_en_v[i] ? mem[i][addr_v[i]] : 8'($urandom);
      p2[i] <= p1[i];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  int n_rd [3], n_win [3], n_done [3], first_rd [3], last_rd [3];
  int first_win [3], last_win [3], done_cyc [3];
  int k10 = 0;
  logic [15:0] exp_addr [3];
  exp_t sb [$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst_n_v[i] === 1'b1) begin
        if (rd_en_v[i]) begin
          chk("rd_addr", 96'(addr_v[i]), 96'(exp_addr[i]));
          if (i == 0 && addr_v[i] == 16'd10) k10 = cyc;
          if (n_rd[i] == 0) first_rd[i] = cyc;
          last_rd[i] = cyc;
          n_rd[i]++;
          exp_addr[i] = exp_addr[i] + 16'd1;
        end
        if (win_valid_v[i]) begin
          if (n_win[i] == 0) first_win[i] = cyc;
          last_win[i] = cyc;
          n_win[i]++;
          chk("sb_has_entry", 96'(sb.size() != 0), 96'(1));
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("window", {6'd0, 2'(i), win_v[i], row_v[i], col_v[i]},
                {6'd0, e.inst, e.w, e.r, e.c});
          end
        end
        if (done_v[i]) begin
          n_done[i]++;
          done_cyc[i] = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int i, input int w, input int h);
    exp_t e;
    for (int r = 1; r < h - 1; r++) begin
      for (int c = 1; c < w - 1; c++) begin
        e.inst = 2'(i);
        e.r    = 8'(r);
        e.c    = 8'(c);
        e.w    = '0;
        for (int dr = 0; dr < 3; dr++)
          for (int dc = 0; dc < 3; dc++)
            e.w[8*(dr*3+dc) +: 8] = mem[i][16'((r - 1 + dr) * w + (c - 1 + dc))];
        sb.push_back(e);
      end
    end
  endtask

  task automatic clear_stats(input int i);
    n_rd[i] = 0; n_win[i] = 0; n_done[i] = 0;
    first_rd[i] = -1; last_rd[i] = -1; first_win[i] = -1; last_win[i] = -1;
    done_cyc[i] = -1; exp_addr[i] = '0;
  endtask

  // pokes=1 pulses start mid-scan and again in the done cycle; both must be ignored.
  task automatic run_frame(input int i, input int w, input int h, input bit pokes);
    bit got;
    push_frame(i, w, h);
    clear_stats(i);
    start_v[i] = 1'b1;
    tick();
    start_v[i] = 1'b0;
    chk("busy_after_start", 96'(busy_v[i]), 96'(1));
    got = 1'b0;
    for (int t = 0; t < w * h + 16; t++) begin
      if (pokes) start_v[i] = (t == 5);
      tick();
      if (done_v[i]) begin got = 1'b1; break; end
    end
    start_v[i] = 1'b0;
    chk("done_seen", 96'(got), 96'(1));
    if (pokes) start_v[i] = 1'b1;
    tick();
    start_v[i] = 1'b0;
    chk("busy_after_done", 96'(busy_v[i]), 96'(0));
    chk("done_count", 96'(n_done[i]), 96'(1));
    chk("rd_count", 96'(n_rd[i]), 96'(w * h));
    chk("rd_consecutive", 96'(last_rd[i] - first_rd[i] + 1), 96'(w * h));
    chk("win_count", 96'(n_win[i]), 96'((w - 2) * (h - 2)));
    chk("sb_empty", 96'(sb.size()), 96'(0));
    chk("done_after_last_win", 96'(done_cyc[i] - last_win[i]), 96'(1));
    chk("done_after_last_rd", 96'(done_cyc[i] - last_rd[i]), 96'(4));
  endtask

  initial begin
    bit got;
    for (int i = 0; i < 3; i++) begin
      rst_n_v[i] = 1'b0;
      start_v[i] = 1'b0;
      clear_stats(i);
    end
    for (int a = 0; a < 65536; a++) begin
      mem[0][a] = (a < 16) ? 8'(a) : 8'd0;
      mem[1][a] = 8'($urandom);
      mem[2][a] = (a < 15) ? 8'(a) : 8'd0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("reset_busy", 96'(busy_v[i]), 96'(0));
      chk("reset_rd_en", 96'(rd_en_v[i]), 96'(0));
      chk("reset_win_valid", 96'(win_valid_v[i]), 96'(0));
      chk("reset_win", 96'(win_v[i]), 96'(0));
    end
    #2;
    for (int i = 0; i < 3; i++) rst_n_v[i] = 1'b1;
    tick();
    tick();

    // 4x4 single frame, then latency from the rd_addr=10 issue cycle
    run_frame(0, 4, 4, 1'b0);
    chk("latency_addr10", 96'(first_win[0] - k10), 96'(3));

    // Ignored starts, then a start one cycle after done gives an identical frame
    run_frame(0, 4, 4, 1'b1);
    run_frame(0, 4, 4, 1'b0);
    chk("latency_second", 96'(first_win[0] - k10), 96'(3));

    // Asynchronous reset mid-frame, between clock edges
    push_frame(0, 4, 4);
    clear_stats(0);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (rd_en_v[0] && addr_v[0] == 16'd14) begin got = 1'b1; break; end
    end
    chk("reach_addr14", 96'(got), 96'(1));
    #2;
    rst_n_v[0] = 1'b0;
    #1;
    chk("arst_busy", 96'(busy_v[0]), 96'(0));
    chk("arst_done", 96'(done_v[0]), 96'(0));
    chk("arst_rd_en", 96'(rd_en_v[0]), 96'(0));
    chk("arst_rd_addr", 96'(addr_v[0]), 96'(0));
    chk("arst_win_valid", 96'(win_valid_v[0]), 96'(0));
    chk("arst_win", 96'(win_v[0]), 96'(0));
    chk("arst_win_row", 96'(row_v[0]), 96'(0));
    chk("arst_win_col", 96'(col_v[0]), 96'(0));
    repeat (3) tick();
    #3;
    rst_n_v[0] = 1'b1;
    sb.delete();
    repeat (3) tick();
    chk("arst_no_done", 96'(n_done[0]), 96'(0));
    chk("arst_idle_busy", 96'(busy_v[0]), 96'(0));
    run_frame(0, 4, 4, 1'b0);
    chk("latency_after_reset", 96'(first_win[0] - k10), 96'(3));

    // 5x3: three windows in one row, no mixing across rows
    run_frame(2, 5, 3, 1'b0);

    // Full-size frame with random contents
    run_frame(1, 256, 256, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
